// File: rtl/wb_commit.sv
// Writeback/commit stage: result select and extension, register file with two read ports,
// commit pulse, retired-instruction counter and ebreak halt. Same-cycle write bypass: WB_COMMIT_BYPASS_EN.
module wb_commit #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   localparam int AW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_wen,
   input  logic [AW-1:0]   in_waddr,
   input  logic [XLEN-1:0] in_ex_res,
   input  logic [XLEN-1:0] in_mem_res,
   input  logic            in_sel_mem,
   input  logic [2:0]      in_ext,
   input  logic [XLEN-1:0] in_pc,
   input  logic            in_ebreak,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [63:0]     instret,
   output logic            halt
);

   // XLEN must be at least 32 and NREG a power of two.
   function automatic logic [XLEN-1:0] extend_data(input logic [XLEN-1:0] raw,
                                                   input logic [2:0]      mode);
      logic [XLEN-1:0] res;
      case (mode)
         3'd0:    res = raw;
         3'd1:    res = XLEN'($signed(raw[31:0]));
         3'd2:    res = XLEN'(raw[31:0]);
         3'd3:    res = XLEN'($signed(raw[15:0]));
         3'd4:    res = XLEN'(raw[15:0]);
         3'd5:    res = XLEN'($signed(raw[7:0]));
         3'd6:    res = XLEN'(raw[7:0]);
         default: res = raw;
      endcase
      return res;
   endfunction

   logic [XLEN-1:0] regs_q [NREG];
   logic            commit_valid_q, commit_valid_d;
   logic [XLEN-1:0] commit_pc_q, commit_pc_d;
   logic [63:0]     instret_q, instret_d;
   logic            halt_q, halt_d;

   logic            accept_s;
   logic            wr_en_s;
   logic [XLEN-1:0] raw_s;
   logic [XLEN-1:0] wr_data_s;
   logic [AW-1:0]   raddr_s [2];
   logic [XLEN-1:0] rdata_s [2];

   always_comb begin
      raw_s          = in_sel_mem ? in_mem_res : in_ex_res;
      wr_data_s      = extend_data(raw_s, in_ext);
      accept_s       = in_valid && !halt_q;
      wr_en_s        = accept_s && in_wen && (in_waddr != {AW{1'b0}}) && (in_ext != 3'd7);
      commit_valid_d = accept_s;
      commit_pc_d    = accept_s ? in_pc : commit_pc_q;
      instret_d      = accept_s ? instret_q + 64'd1 : instret_q;
      // The ebreak request itself still writes and commits; only later requests are blocked.
      halt_d         = halt_q || (accept_s && in_ebreak);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
         commit_valid_q <= 1'b0;
         commit_pc_q    <= {XLEN{1'b0}};
         instret_q      <= 64'd0;
         halt_q         <= 1'b0;
      end else begin
         if (wr_en_s) begin
            regs_q[in_waddr] <= wr_data_s;
         end
         commit_valid_q <= commit_valid_d;
         commit_pc_q    <= commit_pc_d;
         instret_q      <= instret_d;
         halt_q         <= halt_d;
      end
   end

   assign raddr_s[0] = raddr1;
   assign raddr_s[1] = raddr2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata_s[p] = {XLEN{1'b0}};
         if (raddr_s[p] == {AW{1'b0}}) begin
            rdata_s[p] = {XLEN{1'b0}};
`ifdef WB_COMMIT_BYPASS_EN
         end else if (wr_en_s && (raddr_s[p] == in_waddr)) begin
            rdata_s[p] = wr_data_s;
`endif
         end else begin
            rdata_s[p] = regs_q[raddr_s[p]];
         end
      end
   end

   assign in_ready     = !halt_q;
   assign rdata1       = rdata_s[0];
   assign rdata2       = rdata_s[1];
   assign commit_valid = commit_valid_q;
   assign commit_pc    = commit_pc_q;
   assign instret      = instret_q;
   assign halt         = halt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: a reference model tracks registers/instret/halt and a
// queue of expected commit PCs that a negedge monitor consumes.
module tb_wb_commit;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic            in_wen;
   logic [AW-1:0]   in_waddr;
   logic [XLEN-1:0] in_ex_res;
   logic [XLEN-1:0] in_mem_res;
   logic            in_sel_mem;
   logic [2:0]      in_ext;
   logic [XLEN-1:0] in_pc;
   logic            in_ebreak;
   logic [AW-1:0]   raddr1;
   logic [AW-1:0]   raddr2;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic            commit_valid;
   logic [XLEN-1:0] commit_pc;
   logic [63:0]     instret;
   logic            halt;

   int          n_cmp;
   int          n_fail;
   logic [63:0] pc_q[$];
   logic [63:0] model[NREG];
   logic [63:0] exp_instret;
   logic [63:0] exp_pc_last;
   logic        exp_halt;
   bit          mon_en;
   logic [63:0] mon_pc;

   wb_commit #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
      .in_waddr(in_waddr), .in_ex_res(in_ex_res), .in_mem_res(in_mem_res),
      .in_sel_mem(in_sel_mem), .in_ext(in_ext), .in_pc(in_pc), .in_ebreak(in_ebreak),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .instret(instret), .halt(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [2:0] e);
      case (e)
         3'd1:    return {{32{d[31]}}, d[31:0]};
         3'd2:    return {32'h0, d[31:0]};
         3'd3:    return {{48{d[15]}}, d[15:0]};
         3'd4:    return {48'h0, d[15:0]};
         3'd5:    return {{56{d[7]}}, d[7:0]};
         3'd6:    return {56'h0, d[7:0]};
         default: return d;
      endcase
   endfunction

   // Commit scoreboard: every accepted PC must come out exactly one cycle later.
   always @(negedge clk) begin
      if (mon_en) begin
         n_cmp++;
         if (pc_q.size() != 0) begin
            mon_pc = pc_q.pop_front();
            if (commit_valid !== 1'b1 || commit_pc !== mon_pc) begin
               n_fail++;
               $display("FAIL commit_pulse: got valid=%0b pc=%h, want valid=1 pc=%h",
                        commit_valid, commit_pc, mon_pc);
            end
         end else if (commit_valid !== 1'b0 || commit_pc !== exp_pc_last) begin
            n_fail++;
            $display("FAIL commit_idle: got valid=%0b pc=%h, want valid=0 pc=%h",
                     commit_valid, commit_pc, exp_pc_last);
         end
      end
   end

   task automatic idle();
      in_valid = 1'b0; in_wen = 1'b0; in_waddr = '0; in_ex_res = '0; in_mem_res = '0;
      in_sel_mem = 1'b0; in_ext = 3'd0; in_pc = '0; in_ebreak = 1'b0;
   endtask

   task automatic send(input logic wen, input logic [AW-1:0] addr, input logic [63:0] ex,
                       input logic [63:0] mem, input logic sel, input logic [2:0] ext,
                       input logic [63:0] pc, input logic ebrk);
      in_valid = 1'b1; in_wen = wen; in_waddr = addr; in_ex_res = ex; in_mem_res = mem;
      in_sel_mem = sel; in_ext = ext; in_pc = pc; in_ebreak = ebrk;
   endtask

   // Advance one clock from a negedge to the next, updating the reference model at the edge.
   task automatic tick();
      logic acc;
      acc = in_valid && !exp_halt && !rst;
      @(posedge clk);
      if (rst) begin
         foreach (model[i]) model[i] = 64'd0;
         exp_instret = 64'd0; exp_halt = 1'b0; exp_pc_last = 64'd0; pc_q.delete();
      end else if (acc) begin
         pc_q.push_back(in_pc);
         exp_pc_last = in_pc;
         if (in_wen && in_waddr != 0 && in_ext != 3'd7)
            model[in_waddr] = ext_model(in_sel_mem ? in_mem_res : in_ex_res, in_ext);
         exp_instret = exp_instret + 64'd1;
         if (in_ebreak) exp_halt = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); raddr1 = 5'd5; raddr2 = 5'd0;
      tick(); tick();
      rst = 1'b0; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
      n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %0b want 0", halt); end
      n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rst_instret: got %h want 0", instret); end
      n_cmp++; if (commit_valid !== 1'b0 || commit_pc !== 64'd0) begin n_fail++;
         $display("FAIL rst_commit: got valid=%0b pc=%h want 0/0", commit_valid, commit_pc); end
      n_cmp++; if (rdata1 !== 64'd0) begin n_fail++; $display("FAIL rst_x5: got %h want 0", rdata1); end
      mon_en = 1'b1;
   endtask

   task automatic test_ext_sign16();
      send(1'b1, 5'd5, 64'hDEAD_BEEF_0000_1111, 64'h0000_0000_0000_80F0, 1'b1, 3'd3, 64'h100, 1'b0);
      tick(); idle(); raddr1 = 5'd5; #1;
      n_cmp++; if (rdata1 !== 64'hFFFF_FFFF_FFFF_80F0) begin n_fail++;
         $display("FAIL sext16_x5: got %h want ffffffffffff80f0", rdata1); end
      n_cmp++; if (instret !== 64'd1) begin n_fail++; $display("FAIL sext16_instret: got %0d want 1", instret); end
      tick();
   endtask

   task automatic test_x0();
      send(1'b1, 5'd0, 64'h1234, 64'h0, 1'b0, 3'd0, 64'h104, 1'b0);
      raddr1 = 5'd0; tick(); idle(); #1;
      n_cmp++; if (rdata1 !== 64'd0) begin n_fail++; $display("FAIL x0_read: got %h want 0", rdata1); end
      n_cmp++; if (instret !== 64'd2) begin n_fail++; $display("FAIL x0_instret: got %0d want 2", instret); end
   endtask

   task automatic test_ext_modes();
      for (int e = 0; e < 8; e++) begin
         send(1'b1, 5'(16 + e), 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, e[0], 3'(e),
              64'h200 + 64'(4 * e), 1'b0);
         tick();
      end
      idle();
      for (int e = 0; e < 8; e++) begin
         raddr1 = 5'(16 + e); raddr2 = 5'(16 + e); #1;
         n_cmp++; if (rdata1 !== model[16 + e] || rdata2 !== model[16 + e]) begin n_fail++;
            $display("FAIL ext_mode%0d: got r1=%h r2=%h want %h", e, rdata1, rdata2, model[16 + e]); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      rst = 1'b1; idle(); tick(); rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send(1'b0, 5'd7, 64'h0, 64'h0, 1'b0, 3'd0, 64'h8000_0000 + 64'(4 * k), 1'b0);
         tick();
      end
      idle(); #1;
      n_cmp++; if (instret !== 64'd3) begin n_fail++; $display("FAIL b2b_instret: got %0d want 3", instret); end
      tick();
   endtask

   task automatic test_bypass();
      logic [63:0] want;
      send(1'b1, 5'd3, 64'h55, 64'h0, 1'b0, 3'd0, 64'h500, 1'b0);
      tick();
      send(1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0, 3'd6, 64'h504, 1'b0);
      raddr1 = 5'd3; raddr2 = 5'd3; #1;
`ifdef WB_COMMIT_BYPASS_EN
      want = 64'hAB;
`else
      want = 64'h55;
`endif
      n_cmp++; if (rdata1 !== want || rdata2 !== want) begin n_fail++;
         $display("FAIL bypass_same_cycle: got r1=%h r2=%h want %h", rdata1, rdata2, want); end
      tick(); idle(); #1;
      n_cmp++; if (rdata1 !== 64'hAB) begin n_fail++; $display("FAIL bypass_next: got %h want ab", rdata1); end
   endtask

   task automatic test_ebreak();
      logic [63:0] saved;
      send(1'b1, 5'd10, 64'd7, 64'h0, 1'b0, 3'd0, 64'h600, 1'b1);
      tick(); idle(); raddr1 = 5'd10; #1;
      n_cmp++; if (rdata1 !== 64'd7) begin n_fail++; $display("FAIL ebreak_x10: got %h want 7", rdata1); end
      n_cmp++; if (halt !== 1'b1 || in_ready !== 1'b0) begin n_fail++;
         $display("FAIL ebreak_halt: got halt=%0b ready=%0b want 1/0", halt, in_ready); end
      saved = exp_instret;
      send(1'b1, 5'd11, 64'h11, 64'h0, 1'b0, 3'd0, 64'h604, 1'b0);
      tick(); tick(); idle(); raddr1 = 5'd11; #1;
      n_cmp++; if (rdata1 !== 64'd0) begin n_fail++; $display("FAIL halted_x11: got %h want 0", rdata1); end
      n_cmp++; if (instret !== saved) begin n_fail++; $display("FAIL halted_instret: got %0d want %0d", instret, saved); end
      n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %0b want 1", halt); end
   endtask

   task automatic test_reset_priority();
      send(1'b1, 5'd4, 64'h44, 64'h0, 1'b0, 3'd0, 64'h700, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0; idle(); raddr1 = 5'd4; #1;
      n_cmp++; if (rdata1 !== 64'd0) begin n_fail++; $display("FAIL rstprio_x4: got %h want 0", rdata1); end
      n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rstprio_instret: got %0d want 0", instret); end
      n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rstprio_commit: got %0b want 0", commit_valid); end
      n_cmp++; if (halt !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
         $display("FAIL rstprio_halt: got halt=%0b ready=%0b want 0/1", halt, in_ready); end
      tick();
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; mon_en = 1'b0;
      exp_instret = 64'd0; exp_halt = 1'b0; exp_pc_last = 64'd0;
      foreach (model[i]) model[i] = 64'd0;
      rst = 1'b1; idle(); raddr1 = '0; raddr2 = '0;
      test_reset();
      test_ext_sign16();
      test_x0();
      test_ext_modes();
      test_back_to_back();
      test_bypass();
      test_ebreak();
      test_reset_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath and register width.
REQ-002 SHALL have parameter NREG, default 32, register count; AW = clog2(NREG) derived.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  writeback request valid.
REQ-006 SHALL have port in_ready  output  1  block accepts request.
REQ-007 SHALL have port in_wen  input  1  register write requested.
REQ-008 SHALL have port in_waddr  input  AW  destination register.
REQ-009 SHALL have port in_ex_res  input  XLEN  execute-stage result.
REQ-010 SHALL have port in_mem_res  input  XLEN  memory-stage result.
REQ-011 SHALL have port in_sel_mem  input  1  1 selects in_mem_res, 0 selects in_ex_res.
REQ-012 SHALL have port in_ext  input  3  extension mode, per REQ-020.
REQ-013 SHALL have port in_pc  input  XLEN  PC of the request.
REQ-014 SHALL have port in_ebreak  input  1  request is an ebreak.
REQ-015 SHALL have ports raddr1, raddr2  input  AW  read addresses; rdata1, rdata2  output  XLEN  combinational read data.
REQ-016 SHALL have ports commit_valid  output  1, commit_pc  output  XLEN, instret  output  64, halt  output  1.

Function
REQ-017 SHALL accept a request in any cycle where in_valid and in_ready are both 1 ("accept").
REQ-018 SHALL drive in_ready = !halt.
REQ-019 SHALL select raw data from in_mem_res when in_sel_mem = 1, else from in_ex_res.
REQ-020 SHALL extend raw data by in_ext: 0 full XLEN; 1 sign-extend [31:0]; 2 zero-extend [31:0]; 3 sign-extend [15:0]; 4 zero-extend [15:0]; 5 sign-extend [7:0]; 6 zero-extend [7:0]; 7 reserved.
REQ-021 SHALL write extended data to in_waddr on the accept edge when in_wen = 1, in_waddr != 0, and in_ext != 7; otherwise no register changes.
REQ-022 SHALL keep register 0 at zero permanently; reads of address 0 return 0.
REQ-023 SHALL return register contents on rdata1/rdata2 combinationally; both ports independent, same address allowed.
REQ-024 SHALL, one cycle after an accept, assert commit_valid for exactly one cycle with commit_pc = accepted in_pc; commit_valid = 0 in cycles following no accept.
REQ-025 SHALL hold commit_pc at its last value while commit_valid = 0.
REQ-026 SHALL increment instret by 1 on each accept, including reserved in_ext and in_wen = 0; wraps from 2^64-1 to 0.
REQ-027 SHALL set halt on the accept edge of a request with in_ebreak = 1; that request's write and commit still occur; halt stays 1 until reset.
REQ-028 SHALL ignore in_valid while halt = 1: no write, no commit, no instret change.
REQ-029 SHALL support back-to-back accepts every cycle with no bubble.

Reset
REQ-030 SHALL, when rst = 1 at a clock edge, clear all registers to 0, commit_valid to 0, commit_pc to 0, instret to 0, halt to 0.
REQ-031 SHALL give rst priority over a same-cycle accept: that request is discarded, no write, no count.
REQ-032 SHALL drive in_ready = 1 in the first cycle after reset is released.

Configuration
REQ-033 SHALL, with macro WB_COMMIT_BYPASS_EN defined, return the extended write data on rdataN when raddrN equals in_waddr, raddrN != 0, and a qualifying write (REQ-021) is being accepted in the same cycle.
REQ-034 SHALL, without WB_COMMIT_BYPASS_EN, return the pre-write register value in that case; the new value is visible from the next cycle.

Verification
REQ-035 SHALL cover: accept wen=1, waddr=5, sel_mem=1, mem_res=0x00000000_0000_80F0, ext=3 -> x5 = 0xFFFF_FFFF_FFFF_80F0 next cycle; commit_valid pulses one cycle; instret = 1.
REQ-036 SHALL cover: accept waddr=0, ex_res=0x1234, ext=0 -> rdata1 with raddr1=0 reads 0; instret increments.
REQ-037 SHALL cover: three back-to-back accepts, PCs 0x80000000/4/8 -> commit_valid high three consecutive cycles with matching commit_pc; instret = 3.
REQ-038 SHALL cover: accept with ebreak=1, waddr=10, ex_res=7 -> x10 = 7, halt = 1, in_ready = 0; subsequent in_valid for waddr=11 leaves x11 = 0, instret unchanged.
REQ-039 SHALL cover: raddr1 = waddr = 3 during accept of ex_res=0xAB, ext=6 -> rdata1 = 0xAB same cycle with WB_COMMIT_BYPASS_EN, old value without.
REQ-040 SHALL cover: rst=1 coincident with accept of waddr=4 -> x4 = 0, instret = 0, commit_valid = 0 next cycle.
